// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- request/result bundle for the multiply/divide unit.
//
// Signals:
//   start       : request an operation (accepted only while idle)
//   op[1:0]     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b        : multiplicand/dividend, multiplier/divisor
//   hi_we/lo_we : MTHI/MTLO write strobes, data on wdata
//   busy        : operation in progress
//   done        : one-cycle completion pulse
//   div_by_zero : divide-by-zero flag, valid with done
//   hi, lo      : architectural HI/LO registers
//
// Modports: master drives requests (datapath/bench), slave is the unit.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32x32 multiply / 32/32 divide with HI/LO.
//
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : mult_div_unit_if.slave (start/op/a/b, MTHI/MTLO strobes,
//           busy/done/div_by_zero status, hi/lo results)
//
// A start accepted at edge N latches operand magnitudes and sign flags,
// runs one shift-add (multiply) or restoring shift-subtract (divide) step
// on each of edges N+1..N+32, and writes HI/LO with a done pulse at N+33.
// Divide by zero skips the iterations and completes at N+1.
//
// Build option: define MDU_DIV_EN to build the divider. Without it, a
// divide request completes at N+1 with HI/LO unchanged and no flag.
module mult_div_unit (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;

  // Iteration datapath: acc holds {partial product, multiplier} for a
  // multiply and {remainder, dividend/quotient} for a divide.
  logic [63:0] acc;
  logic [31:0] mcand_r;
  logic        is_div_r;
  logic        neg_a_r;
  logic        neg_b_r;

  logic        done_r;
  logic        dbz_out_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        busy;
  logic        step;
  logic        finish;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic        accept;
  logic        op_div;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic        skip_run;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign accept    = (state == IDLE) && bus.start;
  assign op_div    = bus.op[1];
  assign op_signed = ~bus.op[0];
  assign a_neg     = op_signed & bus.a[31];
  assign b_neg     = op_signed & bus.b[31];
  // 0x80000000 negates to itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

`ifdef MDU_DIV_EN
  logic div_zero;
  logic dbz_r;
  assign div_zero = op_div && (bus.b == '0);
  assign skip_run = div_zero;
`else
  assign skip_run = op_div;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values; = here would create order-dependent simulation races.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps every path assigned, so no
  // latch is inferred when a case branch leaves it untouched.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = skip_run ? FIN : RUN;
      RUN:     if (cnt == 6'd31) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    step   = (state == RUN);
    finish = (state == FIN);
  end

  // ---------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand_r} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};

`ifdef MDU_DIV_EN
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  // Partial remainder is always below the divisor, so the 33-bit
  // difference borrows (bit 32 set) exactly when the subtract must be undone.
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, mcand_r};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0],  acc[30:0], 1'b1};
`endif

  // NOTE: the operand/iteration registers carry no reset: they are always
  // loaded on accept before being read, and HI/LO ignore them until FIN.
  always_ff @(posedge clock) begin
    if (accept) begin
      is_div_r <= op_div;
      neg_a_r  <= a_neg;
      neg_b_r  <= b_neg;
`ifdef MDU_DIV_EN
      dbz_r    <= div_zero;
`endif
      if (op_div) begin
        mcand_r <= b_mag;
`ifdef MDU_DIV_EN
        // Divide by zero returns the raw dividend in HI.
        acc     <= {32'd0, div_zero ? bus.a : a_mag};
`else
        acc     <= {32'd0, a_mag};
`endif
      end else begin
        mcand_r <= a_mag;
        acc     <= {32'd0, b_mag};
      end
    end else if (step) begin
`ifdef MDU_DIV_EN
      acc <= is_div_r ? div_next : mul_next;
`else
      acc <= mul_next;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Result sign fix-up
  // ---------------------------------------------------------------------
  logic [63:0] acc_neg;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        wr_result;
  logic        dbz_hit;

  assign acc_neg = -acc;

  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
    if (!is_div_r) begin
      if (neg_a_r ^ neg_b_r) {res_hi, res_lo} = acc_neg;
    end
`ifdef MDU_DIV_EN
    else if (dbz_r) begin
      res_hi = acc[31:0];
      res_lo = '1;
    end else begin
      // Quotient truncates toward zero; remainder follows the dividend.
      if (neg_a_r ^ neg_b_r) res_lo = -acc[31:0];
      if (neg_a_r)           res_hi = -acc[63:32];
    end
`endif
  end

`ifdef MDU_DIV_EN
  assign wr_result = 1'b1;
  assign dbz_hit   = dbz_r;
`else
  assign wr_result = ~is_div_r;
  assign dbz_hit   = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Architectural state: counter, status pulses, HI/LO
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      done_r    <= finish;
      dbz_out_r <= finish & dbz_hit;

      if (accept)    cnt <= '0;
      else if (step) cnt <= cnt + 6'd1;

      if (finish) begin
        if (wr_result) begin
          hi_r <= res_hi;
          lo_r <= res_lo;
        end
      end else if (!busy) begin
        // A strobe coinciding with start lands now and is overwritten
        // by the result at completion.
        if (bus.hi_we) hi_r <= bus.wdata;
        if (bus.lo_we) lo_r <= bus.wdata;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_out_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule
